// File: rtl/matmul_pkg.sv
// Shared encodings, types and field helpers for the matrix multiply-accumulate datapath.
// MATMUL_SATURATE_EN selects the saturation limits used by dot_product_unit.
package matmul_pkg;

  typedef enum logic [1:0] {
    PREC_FULL    = 2'd0,
    PREC_PACKED4 = 2'd1,
    PREC_MIXED   = 2'd2
  } prec_mode_e;

  localparam int HALVED_PACKED_BIT = 1;

  localparam logic [3:0] BITSIZE_4 = 4'd2;
  localparam logic [3:0] BITSIZE_8 = 4'd4;

  // Two guard bits above the 32-bit result make overflow visible before wrap or clamp.
  localparam int SUM_W = 34;

  typedef logic signed [31:0]      acc_t;
  typedef logic signed [SUM_W-1:0] sum_t;

  localparam acc_t ACC_MAX    = acc_t'(32'h7FFF_FFFF);
  localparam acc_t ACC_MIN    = acc_t'(32'h8000_0000);
  localparam sum_t SUM_SAT_HI = sum_t'(ACC_MAX);
  localparam sum_t SUM_SAT_LO = sum_t'(ACC_MIN);

  function automatic sum_t sign_extend_field(input sum_t raw, input int width);
    sum_t v;
    v = raw <<< (SUM_W - width);
    return v >>> (SUM_W - width);
  endfunction

  // Only 2 selects a 4-bit operand; every other code falls back to 8 bits.
  function automatic int bitsize_width(input logic [3:0] bs);
    return (bs == BITSIZE_4) ? 4 : 2 * int'(BITSIZE_8);
  endfunction

endpackage

// File: rtl/dot_product_unit.sv
// One K-length signed dot product plus accumulator with packed/mixed precision handling.
// MATMUL_SATURATE_EN clamps the result to 32-bit signed range instead of wrapping.
module dot_product_unit
  import matmul_pkg::*;
#(
  parameter int K    = 2,
  parameter int P    = 8,
  parameter int TREE = 0,
  parameter int MODE = 0
) (
  input  logic signed [P-1:0] i_a [K],
  input  logic signed [P-1:0] i_b [K],
  input  logic signed [31:0]  i_c,
  input  logic                i_packed,
  input  logic [3:0]          i_bitsize_a,
  input  logic [3:0]          i_bitsize_b,
  output logic signed [31:0]  o_d
);

  localparam bit PACKED_EN = (MODE >= int'(PREC_PACKED4));
  localparam bit MIXED_EN  = (MODE == int'(PREC_MIXED));
  localparam int NPAD      = (K > 1) ? (1 << $clog2(K)) : 1;

  logic w_packed;
  int   w_width_a;
  int   w_width_b;
  sum_t w_term [K];
  sum_t w_sum;

  assign w_packed  = PACKED_EN && i_packed;
  assign w_width_a = MIXED_EN ? bitsize_width(i_bitsize_a) : P;
  assign w_width_b = MIXED_EN ? bitsize_width(i_bitsize_b) : P;

  // Packed lanes only multiply hi*hi and lo*lo; there are no cross products.
  always_comb begin
    for (int k = 0; k < K; k++) begin
      if (w_packed) begin
        w_term[k] = sign_extend_field(sum_t'(i_a[k][7:4]), 4) * sign_extend_field(sum_t'(i_b[k][7:4]), 4)
                  + sign_extend_field(sum_t'(i_a[k][3:0]), 4) * sign_extend_field(sum_t'(i_b[k][3:0]), 4);
      end else begin
        w_term[k] = sign_extend_field(sum_t'(i_a[k]), w_width_a)
                  * sign_extend_field(sum_t'(i_b[k]), w_width_b);
      end
    end
  end

  always_comb begin
    sum_t lvl [NPAD];
    for (int n = 0; n < NPAD; n++) lvl[n] = '0;
    w_sum = sum_t'(i_c);
    if (TREE != 0) begin
      for (int k = 0; k < K; k++) lvl[k] = w_term[k];
      // In-place pairwise halving: slot n is written only after slots 2n and 2n+1 are read.
      for (int span = NPAD / 2; span > 0; span = span / 2) begin
        for (int n = 0; n < span; n++) lvl[n] = lvl[2*n] + lvl[2*n+1];
      end
      w_sum = sum_t'(i_c) + lvl[0];
    end else begin
      for (int k = 0; k < K; k++) w_sum = w_sum + w_term[k];
    end
  end

  always_comb begin
`ifdef MATMUL_SATURATE_EN
    if (w_sum > SUM_SAT_HI) begin
      o_d = ACC_MAX;
    end else if (w_sum < SUM_SAT_LO) begin
      o_d = ACC_MIN;
    end else begin
      o_d = acc_t'(w_sum);
    end
`else
    o_d = acc_t'(w_sum);
`endif
  end

endmodule

// File: rtl/matrix_multiplication_accumulation.sv
// D = A*B + C behind a single valid/ready stage; optional registered result (MANUAL_PIPELINE).
// Build macro MATMUL_SATURATE_EN switches result wrap to saturation.
module matrix_multiplication_accumulation
  import matmul_pkg::*;
#(
  parameter int M               = 2,
  parameter int N               = 2,
  parameter int K               = 2,
  parameter int P               = 8,
  parameter int TREE            = 0,
  parameter int MODE            = 0,
  parameter int MANUAL_PIPELINE = 0
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic signed [P-1:0] A [M][K],
  input  logic signed [P-1:0] B [K][N],
  input  logic signed [31:0]  C [M][N],
  output logic signed [31:0]  D [M][N],
  input  logic [1:0]         halvedPrecision,
  input  logic [3:0]         bitSizeA,
  input  logic [3:0]         bitSizeB,
  input  logic               valid_in,
  output logic               ready_in,
  output logic               valid_out,
  input  logic               ready_out
);

  logic r_valid_out;
  logic w_accept;
  logic w_unused_hp0;
  logic signed [31:0] w_d [M][N];

  assign ready_in     = !r_valid_out || ready_out;
  assign w_accept     = valid_in && ready_in;
  assign valid_out    = r_valid_out;
  assign w_unused_hp0 = halvedPrecision[0];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid_out <= 1'b0;
    end else if (w_accept) begin
      r_valid_out <= 1'b1;
    end else if (ready_out) begin
      r_valid_out <= 1'b0;
    end
  end

  for (genvar gi = 0; gi < M; gi++) begin : g_row
    for (genvar gj = 0; gj < N; gj++) begin : g_col
      logic signed [P-1:0] w_a_row [K];
      logic signed [P-1:0] w_b_col [K];
      for (genvar gk = 0; gk < K; gk++) begin : g_k
        assign w_a_row[gk] = A[gi][gk];
        assign w_b_col[gk] = B[gk][gj];
      end
      dot_product_unit #(
        .K    (K),
        .P    (P),
        .TREE (TREE),
        .MODE (MODE)
      ) u_dpu (
        .i_a         (w_a_row),
        .i_b         (w_b_col),
        .i_c         (C[gi][gj]),
        .i_packed    (halvedPrecision[HALVED_PACKED_BIT]),
        .i_bitsize_a (bitSizeA),
        .i_bitsize_b (bitSizeB),
        .o_d         (w_d[gi][gj])
      );
    end
  end

  // Capturing the result on accept is equivalent to capturing the operands, and D then holds under backpressure.
  if (MANUAL_PIPELINE != 0) begin : g_pipe
    logic signed [31:0] r_d [M][N];
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int i = 0; i < M; i++) begin
          for (int j = 0; j < N; j++) r_d[i][j] <= '0;
        end
      end else if (w_accept) begin
        r_d <= w_d;
      end
    end
    assign D = r_d;
  end else begin : g_comb
    assign D = w_d;
  end

endmodule

// File: tb/tb_matrix_multiplication_accumulation.sv
// Randomised self-checking bench: three configurations driven in parallel against an arithmetic reference model.
module tb_matrix_multiplication_accumulation;
  localparam int M = 2;
  localparam int N = 2;
  localparam int K = 2;
  localparam int P = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic signed [P-1:0] A [M][K];
  logic signed [P-1:0] B [K][N];
  logic signed [31:0]  C [M][N];
  logic signed [31:0]  d0 [M][N];
  logic signed [31:0]  d1 [M][N];
  logic signed [31:0]  d2 [M][N];
  logic [31:0] hold [M][N];
  logic [1:0] hp;
  logic [3:0] bsa, bsb;
  logic valid_in, ready_out;
  logic vo0, vo1, vo2, ri0, ri1, ri2;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  matrix_multiplication_accumulation #(.M(M), .N(N), .K(K), .P(P), .TREE(1), .MODE(0), .MANUAL_PIPELINE(1)) u_m0 (
    .clk_i(clk), .rst_ni(rst_n), .A(A), .B(B), .C(C), .D(d0), .halvedPrecision(hp), .bitSizeA(bsa),
    .bitSizeB(bsb), .valid_in(valid_in), .ready_in(ri0), .valid_out(vo0), .ready_out(ready_out));
  matrix_multiplication_accumulation #(.M(M), .N(N), .K(K), .P(P), .TREE(0), .MODE(1), .MANUAL_PIPELINE(0)) u_m1 (
    .clk_i(clk), .rst_ni(rst_n), .A(A), .B(B), .C(C), .D(d1), .halvedPrecision(hp), .bitSizeA(bsa),
    .bitSizeB(bsb), .valid_in(valid_in), .ready_in(ri1), .valid_out(vo1), .ready_out(ready_out));
  matrix_multiplication_accumulation #(.M(M), .N(N), .K(K), .P(P), .TREE(1), .MODE(2), .MANUAL_PIPELINE(0)) u_m2 (
    .clk_i(clk), .rst_ni(rst_n), .A(A), .B(B), .C(C), .D(d2), .halvedPrecision(hp), .bitSizeA(bsa),
    .bitSizeB(bsb), .valid_in(valid_in), .ready_in(ri2), .valid_out(vo2), .ready_out(ready_out));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", tag, $signed(got), got, $signed(exp), exp);
    end
  endtask

  // Low 'bits' bits of raw read as a two's-complement number.
  function automatic int fld(input int raw, input int bits);
    int m, v;
    m = 1 << bits;
    v = raw & (m - 1);
    return (v >= m / 2) ? v - m : v;
  endfunction

  function automatic logic [31:0] model_d(input int mode, input int i, input int j);
    longint s;
    int wa, wb, ua, ub;
    s  = longint'(C[i][j]);
    wa = 8;
    wb = 8;
    if (mode == 2) begin
      wa = (bsa == 4'd2) ? 4 : 8;
      wb = (bsb == 4'd2) ? 4 : 8;
    end
    for (int k = 0; k < K; k++) begin
      ua = int'(A[i][k]) & 255;
      ub = int'(B[k][j]) & 255;
      if (mode >= 1 && hp[1])
        s += longint'(fld(ua >> 4, 4) * fld(ub >> 4, 4) + fld(ua, 4) * fld(ub, 4));
      else
        s += longint'(fld(ua, wa) * fld(ub, wb));
    end
`ifdef MATMUL_SATURATE_EN
    if (s > 64'sd2147483647) s = 64'sd2147483647;
    if (s < -64'sd2147483648) s = -64'sd2147483648;
`endif
    return s[31:0];
  endfunction

  task automatic check_hs(input string tag, input logic exp_valid);
    logic exp_ready;
    exp_ready = !exp_valid || ready_out;
    check({tag, "_m0_valid"}, vo0, exp_valid);
    check({tag, "_m1_valid"}, vo1, exp_valid);
    check({tag, "_m2_valid"}, vo2, exp_valid);
    check({tag, "_m0_ready"}, ri0, exp_ready);
    check({tag, "_m1_ready"}, ri1, exp_ready);
    check({tag, "_m2_ready"}, ri2, exp_ready);
  endtask

  task automatic check_all_d(input string tag, input bit m2_ok);
    for (int i = 0; i < M; i++) begin
      for (int j = 0; j < N; j++) begin
        check($sformatf("%s_m0_d%0d%0d", tag, i, j), d0[i][j], model_d(0, i, j));
        check($sformatf("%s_m1_d%0d%0d", tag, i, j), d1[i][j], model_d(1, i, j));
        if (m2_ok) check($sformatf("%s_m2_d%0d%0d", tag, i, j), d2[i][j], model_d(2, i, j));
      end
    end
  endtask

  task automatic txn(input string tag);
    @(negedge clk);
    valid_in = 1'b1;
    @(posedge clk);
    #1;
    check_hs(tag, 1'b1);
    check_all_d(tag, !hp[1]);
  endtask

  task automatic clear_ops();
    for (int i = 0; i < M; i++) for (int k = 0; k < K; k++) A[i][k] = '0;
    for (int k = 0; k < K; k++) for (int j = 0; j < N; j++) B[k][j] = '0;
    for (int i = 0; i < M; i++) for (int j = 0; j < N; j++) C[i][j] = '0;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < M; i++) for (int k = 0; k < K; k++) A[i][k] = P'($urandom_range(0, 255));
    for (int k = 0; k < K; k++) for (int j = 0; j < N; j++) B[k][j] = P'($urandom_range(0, 255));
    for (int i = 0; i < M; i++) for (int j = 0; j < N; j++) C[i][j] = $urandom;
  endtask

  function automatic logic [3:0] rand_bs();
    int r;
    r = $urandom_range(0, 3);
    if (r == 0) return 4'd2;
    if (r == 1) return 4'd4;
    return 4'($urandom_range(0, 15));
  endfunction

  initial begin
    valid_in = 1'b0; ready_out = 1'b1; hp = 2'b00; bsa = 4'd4; bsb = 4'd4;
    clear_ops();
    #1;
    check_hs("reset", 1'b0);
    for (int i = 0; i < M; i++) for (int j = 0; j < N; j++) check($sformatf("reset_m0_d%0d%0d", i, j), d0[i][j], 32'd0);
    #12 rst_n = 1'b1;

    // Basic 2x2x2 product
    A[0][0] = 8'sd1; A[0][1] = 8'sd2; A[1][0] = 8'sd3; A[1][1] = 8'sd4;
    B[0][0] = 8'sd5; B[0][1] = 8'sd6; B[1][0] = 8'sd7; B[1][1] = 8'sd8;
    for (int i = 0; i < M; i++) for (int j = 0; j < N; j++) C[i][j] = 32'sd1;
    txn("t1");
    check("t1_lit_d00", d1[0][0], 32'd20);
    check("t1_lit_d01", d1[0][1], 32'd23);
    check("t1_lit_d10", d1[1][0], 32'd44);
    check("t1_lit_d11", d0[1][1], 32'd51);
    valid_in = 1'b0;
    @(posedge clk); #1;
    check_hs("t1_drain", 1'b0);

    // Signed extremes and overflow
    for (int i = 0; i < M; i++) for (int k = 0; k < K; k++) A[i][k] = -8'sd128;
    for (int k = 0; k < K; k++) for (int j = 0; j < N; j++) B[k][j] = -8'sd128;
    for (int i = 0; i < M; i++) for (int j = 0; j < N; j++) C[i][j] = 32'sd0;
    txn("t2a");
    check("t2a_lit", d0[0][0], 32'd32768);
    for (int i = 0; i < M; i++) for (int j = 0; j < N; j++) C[i][j] = 32'h7FFF_FFFF;
    txn("t2b");
`ifdef MATMUL_SATURATE_EN
    check("t2b_lit", d1[1][1], 32'h7FFF_FFFF);
`else
    check("t2b_lit", d1[1][1], 32'h8000_7FFF);
`endif

    // Packed dual-4-bit
    clear_ops();
    hp = 2'b10;
    A[0][0] = 8'h21; B[0][0] = 8'h3F;
    txn("t3");
    check("t3_lit_m1", d1[0][0], 32'd5);
    check("t3_lit_m0", d0[0][0], 32'd2079);

    // Mixed widths
    clear_ops();
    hp = 2'b00; bsa = 4'd4; bsb = 4'd2;
    A[0][0] = 8'sd100; B[0][0] = 8'h0F; C[0][0] = 32'sd7;
    txn("t4");
    check("t4_lit_m2", d2[0][0], -32'sd93);
    check("t4_lit_m1", d1[0][0], 32'd1507);
    valid_in = 1'b0;
    @(posedge clk); #1;
    check_hs("t4_drain", 1'b0);

    // Backpressure: result and flag hold, blocked valid_in is not taken
    rand_ops();
    hp = 2'b00; bsa = 4'd4; bsb = 4'd4;
    ready_out = 1'b0;
    txn("t5");
    for (int i = 0; i < M; i++) for (int j = 0; j < N; j++) hold[i][j] = model_d(0, i, j);
    rand_ops();
    repeat (2) begin
      @(posedge clk); #1;
      check_hs("t5_stall", 1'b1);
      for (int i = 0; i < M; i++) for (int j = 0; j < N; j++) check($sformatf("t5_hold_d%0d%0d", i, j), d0[i][j], hold[i][j]);
    end
    valid_in = 1'b0; ready_out = 1'b1;
    @(posedge clk); #1;
    check_hs("t5_release", 1'b0);

    // Reset while a result is pending
    rand_ops();
    txn("t6");
    valid_in = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_hs("t6_rst", 1'b0);
    for (int i = 0; i < M; i++) for (int j = 0; j < N; j++) check($sformatf("t6_rst_m0_d%0d%0d", i, j), d0[i][j], 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back random transactions: every edge both drains and accepts
    for (int n = 0; n < 40; n++) begin
      rand_ops();
      hp  = 2'($urandom_range(0, 3));
      bsa = rand_bs();
      bsb = rand_bs();
      txn($sformatf("rnd%0d", n));
    end
    valid_in = 1'b0;
    @(posedge clk); #1;
    check_hs("rnd_drain", 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
